// File: rtl/exe_loop_ctrl_if.sv
// Handshake bundle between the src loader / write-back side and the execution-loop sequencer.
// The sequencer attaches through the slave modport; the environment attaches through master.
interface exe_loop_ctrl_if #(
    parameter int ROW_W  = 3,
    parameter int SRC_AW = 5,
    parameter int MAT_AW = 3
);
    logic              s_init;
    logic [ROW_W-1:0]  n_rows;
    logic              out_busy;
    logic              out_fin;
    logic              abort;
    logic              s_fin;
    logic              k_init;
    logic              k_fin;
    logic              exec;
    logic [SRC_AW-1:0] exec_src_addr;
    logic [MAT_AW-1:0] exec_mat_addr;
    logic [ROW_W-1:0]  exec_row;
    logic              busy;

    modport master (
        output s_init, n_rows, out_busy, out_fin, abort,
        input  s_fin, k_init, k_fin, exec, exec_src_addr, exec_mat_addr, exec_row, busy
    );

    modport slave (
        input  s_init, n_rows, out_busy, out_fin, abort,
        output s_fin, k_init, k_fin, exec, exec_src_addr, exec_mat_addr, exec_row, busy
    );
endinterface

// File: rtl/exe_loop_ctrl.sv
// Row/column execution-loop sequencer: one k_init-framed burst of COLS exec cycles per row,
// with runtime row count, per-row write-back back-pressure, abort and a job-done pulse.
module exe_loop_ctrl #(
    parameter int ROWS   = 4,
    parameter int COLS   = 8,
    parameter int SRC_AW = 5,
    parameter int MAT_AW = 3,
    parameter int ROW_W  = 3
) (
    input  logic            clk,
    input  logic            rst,
    exe_loop_ctrl_if.slave  bus
);

    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    state_t           state_q;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] nrows_q;
    logic [ROW_W-1:0] nrows_d;
    logic [CW-1:0]    col_q;
    logic             k_fin_q;
    logic             s_fin_q;
    logic             col_last;
    logic             row_last;
    logic             in_run;

    // A zero or oversized request runs the full ROWS iterations.
    always_comb begin
        nrows_d = bus.n_rows;
        if (bus.n_rows == '0 || bus.n_rows > ROW_W'(ROWS)) begin
            nrows_d = ROW_W'(ROWS);
        end
    end

    assign col_last = (col_q == CW'(COLS - 1));
    assign row_last = (row_q == nrows_q - 1'b1);
    assign in_run   = (state_q == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            nrows_q <= '0;
            col_q   <= '0;
            k_fin_q <= 1'b0;
            s_fin_q <= 1'b0;
        end else begin
            k_fin_q <= 1'b0;
            s_fin_q <= 1'b0;
            if (bus.abort) begin
                state_q <= IDLE;
                row_q   <= '0;
                col_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.s_init) begin
                            nrows_q <= nrows_d;
                            row_q   <= '0;
                            col_q   <= '0;
                            state_q <= ARM;
                        end
                    end
                    ARM: begin
                        if (!bus.out_busy) begin
                            state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (col_last) begin
                            col_q   <= '0;
                            k_fin_q <= 1'b1;
                            if (row_last) begin
                                state_q <= DRAIN;
                            end else begin
                                row_q   <= row_q + 1'b1;
                                state_q <= ARM;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (bus.out_fin) begin
                            s_fin_q <= 1'b1;
                            row_q   <= '0;
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    // k_init follows the live out_busy so a row launches in the first cycle write-back frees up.
    assign bus.k_init        = (state_q == ARM) && !bus.out_busy && !bus.abort;
    assign bus.k_fin         = k_fin_q;
    assign bus.s_fin         = s_fin_q;
    assign bus.exec          = in_run;
    assign bus.busy          = (state_q != IDLE);
    assign bus.exec_row      = row_q;
    assign bus.exec_mat_addr = in_run ? MAT_AW'(col_q) : '0;
    assign bus.exec_src_addr = in_run ? (SRC_AW'(row_q) * SRC_AW'(COLS) + SRC_AW'(col_q)) : '0;

endmodule

// File: doc/exe_loop_ctrl.md
Name: exe_loop_ctrl

Overview:
Parametrised execution-loop sequencer for the compute datapath, generalising the fixed 4x8 row/column controller.
- Accepts a source buffer once it is loaded, and issues one kernel pass per row. Each pass is COLS exec cycles with src/matrix read addresses.
- Adds a runtime row count, output back-pressure per row, abort, and a busy flag.
- Sits between the src buffer loader and the output write-back unit.

Parameters:
ROWS, 4, maximum row (i-loop) iterations
COLS, 8, column (j-loop) iterations per row
SRC_AW, 5, src address width, must be >= clog2(ROWS*COLS)
MAT_AW, 3, matrix address width, must be >= clog2(COLS)
ROW_W, 3, width of n_rows/exec_row, must be >= clog2(ROWS+1)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  reset, asynchronous, active-low
s_init  input  1  start pulse: src buffer ready
n_rows  input  ROW_W  rows to run, sampled with s_init
out_busy  input  1  write-back cannot accept a new row
out_fin  input  1  write-back has committed all results
abort  input  1  synchronous cancel
s_fin  output  1  one-cycle pulse: whole job written back
k_init  output  1  one-cycle pulse before each row's exec burst
k_fin  output  1  one-cycle pulse after each row's last exec
exec  output  1  high during each of COLS column cycles
exec_src_addr  output  SRC_AW  exec_row*COLS + column
exec_mat_addr  output  MAT_AW  column index
exec_row  output  ROW_W  current row index
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst low, asynchronous): state IDLE. Row and column counters are 0. All outputs are 0.
- States: IDLE, ARM, RUN, DRAIN.
- IDLE:
  - On s_init, latch n_rows. A value of 0 or greater than ROWS is clamped to ROWS.
  - Set row=0 and go to ARM on the next cycle.
  - s_init outside IDLE is ignored.
- ARM:
  - If !out_busy, drive k_init=1 for this cycle and go to RUN.
  - Otherwise hold in ARM with k_init=0; there is no timeout.
- RUN:
  - exec=1 every cycle; the column counter runs 0..COLS-1.
  - exec_src_addr = row*COLS+col, computed unsigned and truncated to SRC_AW. exec_mat_addr = col.
  - On col==COLS-1, col wraps to 0. If row==n_rows-1, go to DRAIN; otherwise row++ and go to ARM.
- k_fin:
  - Registered from the last-column cycle, so it pulses in the first cycle of the following ARM or DRAIN.
  - k_fin and k_init may assert in the same cycle.
- DRAIN:
  - out_fin is sampled only in DRAIN. out_fin seen in any other state is ignored.
  - When out_fin is seen, s_fin pulses on the next cycle (registered) and the state returns to IDLE in that same cycle.
  - A new s_init is accepted in the cycle s_fin is high.
- Outputs outside exec: exec_src_addr and exec_mat_addr are 0. exec_row holds the current row while busy and is 0 in IDLE.
- abort:
  - Highest priority. Next cycle: IDLE with counters cleared.
  - Any pending k_fin or s_fin pulse is suppressed, and no s_fin is issued for the aborted job.
- Latency with defaults and out_busy=0, s_init at cycle 0:
  - k_init at cycle 1.
  - Row r: exec over cycles 2+9r .. 9+9r; k_fin at 10+9r.
- Throughput: COLS+1 cycles per row with no back-pressure.

Test Plan:
- Defaults, n_rows=4, out_busy=0, s_init@0, out_fin@40:
  - k_init @1,10,19,28; exec bursts 2-9, 11-18, 20-27, 29-36; k_fin @10,19,28,37; s_fin @41.
  - src addr 0..31 in order; mat addr 0..7 repeated per row.
- n_rows=0 and n_rows=7 -> both run exactly 4 rows (clamp). n_rows=1 -> a single burst with addresses 0..7, then DRAIN.
- out_busy high over cycles 10-14 -> second k_init at 15, second burst at 16-23, first burst unaffected.
- abort asserted at cycle 20, mid row 2 -> exec=0 and busy=0 from cycle 21; no k_fin or s_fin follows. A following s_init restarts at src addr 0.
- out_fin pulsed at cycle 5 (during RUN) -> ignored; s_fin occurs only after an out_fin seen in DRAIN. s_init asserted at cycle 12 -> ignored.
- ROWS=8, COLS=16, SRC_AW=7, MAT_AW=4, ROW_W=4, n_rows=8:
  - 8 bursts of 16; last src addr 127; row period 17 cycles.
- rst pulled low mid-RUN -> all outputs 0 immediately. After release, state is IDLE and no pulses occur without s_init.
